// File: rtl/board_io_ctrl.sv
// Board I/O service block: multiplexed 7-segment scanner, switch synchroniser/debouncer
// and heartbeat, all in the system clock domain.
module board_io_ctrl #(
  parameter int unsigned NUM_OF_ANODES   = 4,
  parameter int unsigned NUM_SWITCHES    = 3,
  parameter int unsigned SCAN_CYCLES     = 12000,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned HEARTBEAT_BIT   = 23
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_i,
  input  logic [4*NUM_OF_ANODES-1:0]   digits_i,
  input  logic [NUM_OF_ANODES-1:0]     dp_i,
  input  logic [NUM_OF_ANODES-1:0]     blank_i,
  output logic [NUM_OF_ANODES-1:0]     an_o,
  output logic [6:0]                   seg_o,
  output logic                         dp_o,
  input  logic [NUM_SWITCHES-1:0]      sw_i,
  output logic [NUM_SWITCHES-1:0]      sw_o,
  output logic [NUM_SWITCHES-1:0]      sw_rise_o,
  output logic [NUM_SWITCHES-1:0]      sw_fall_o,
  output logic                         heartbeat_o
);

  localparam int unsigned ScanW = $clog2(SCAN_CYCLES);
  localparam int unsigned IdxW  = (NUM_OF_ANODES > 1) ? $clog2(NUM_OF_ANODES) : 1;
  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HbW   = HEARTBEAT_BIT + 1;

  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_CYCLES - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_OF_ANODES - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    unique case (nib)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Scanner
  logic [ScanW-1:0]                 scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]                  scan_idx_q, scan_idx_d;
  logic [NUM_OF_ANODES-1:0][3:0]    shadow_dig_q;
  logic [NUM_OF_ANODES-1:0]         shadow_dp_q, shadow_blank_q;
  logic                             shadow_load;
  logic [NUM_OF_ANODES-1:0]         an_q, an_d;
  logic [6:0]                       seg_q, seg_d;
  logic                             dp_q, dp_d;

  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    scan_idx_d  = scan_idx_q;
    shadow_load = ~enable_i;
    an_d        = '1;
    seg_d       = 7'h7F;
    dp_d        = 1'b1;
    if (!enable_i) begin
      scan_cnt_d = '0;
      scan_idx_d = '0;
    end else begin
      if (scan_cnt_q == ScanLast) begin
        scan_cnt_d  = '0;
        scan_idx_d  = (scan_idx_q == IdxLast) ? '0 : scan_idx_q + IdxW'(1);
        // Shadow only refreshes on the frame boundary so a frame never mixes old/new digits
        shadow_load = (scan_idx_q == IdxLast);
      end else begin
        scan_cnt_d = scan_cnt_q + ScanW'(1);
      end
      if (!shadow_blank_q[scan_idx_q]) begin
        an_d  = ~(NUM_OF_ANODES'(1) << scan_idx_q);
        seg_d = hex_to_seg(shadow_dig_q[scan_idx_q]);
        dp_d  = ~shadow_dp_q[scan_idx_q];
      end
    end
  end

  // Debouncer
  logic [NUM_SWITCHES-1:0]            sync1_q, sync2_q;
  logic [NUM_SWITCHES-1:0]            sw_q, sw_d, rise_q, rise_d, fall_q, fall_d;
  logic [NUM_SWITCHES-1:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;

  always_comb begin
    sw_d      = sw_q;
    rise_d    = '0;
    fall_d    = '0;
    deb_cnt_d = deb_cnt_q;
    for (int k = 0; k < NUM_SWITCHES; k++) begin
      if (sync2_q[k] == sw_q[k]) begin
        deb_cnt_d[k] = '0;
      end else if (deb_cnt_q[k] == DebLast) begin
        deb_cnt_d[k] = '0;
        sw_d[k]      = ~sw_q[k];
        rise_d[k]    = ~sw_q[k];
        fall_d[k]    = sw_q[k];
      end else begin
        deb_cnt_d[k] = deb_cnt_q[k] + DebW'(1);
      end
    end
  end

  logic [HbW-1:0] hb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q     <= '0;
      scan_idx_q     <= '0;
      shadow_dig_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      an_q           <= '1;
      seg_q          <= 7'h7F;
      dp_q           <= 1'b1;
      sync1_q        <= '0;
      sync2_q        <= '0;
      sw_q           <= '0;
      rise_q         <= '0;
      fall_q         <= '0;
      deb_cnt_q      <= '0;
      hb_q           <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      if (shadow_load) begin
        shadow_dig_q   <= digits_i;
        shadow_dp_q    <= dp_i;
        shadow_blank_q <= blank_i;
      end
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      sync1_q   <= sw_i;
      sync2_q   <= sync1_q;
      sw_q      <= sw_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      deb_cnt_q <= deb_cnt_d;
      hb_q      <= hb_q + HbW'(1);
    end
  end

  assign an_o        = an_q;
  assign seg_o       = seg_q;
  assign dp_o        = dp_q;
  assign sw_o        = sw_q;
  assign sw_rise_o   = rise_q;
  assign sw_fall_o   = fall_q;
  assign heartbeat_o = hb_q[HEARTBEAT_BIT];

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl: cycle model plus directed literal checks.
module tb_board_io_ctrl;

  localparam int N  = 4;
  localparam int M  = 3;
  localparam int SC = 4;
  localparam int DB = 5;
  localparam int HB = 3;

  logic           clk = 1'b0;
  logic           reset, enable_i;
  logic [4*N-1:0] digits_i;
  logic [N-1:0]   dp_i, blank_i, an_o;
  logic [6:0]     seg_o;
  logic           dp_o, heartbeat_o;
  logic [M-1:0]   sw_i, sw_o, sw_rise_o, sw_fall_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  board_io_ctrl #(
    .NUM_OF_ANODES  (N),
    .NUM_SWITCHES   (M),
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_CYCLES(DB),
    .HEARTBEAT_BIT  (HB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (enable_i),
    .digits_i   (digits_i),
    .dp_i       (dp_i),
    .blank_i    (blank_i),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .sw_i       (sw_i),
    .sw_o       (sw_o),
    .sw_rise_o  (sw_rise_o),
    .sw_fall_o  (sw_fall_o),
    .heartbeat_o(heartbeat_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  bit         m_valid = 0;
  int         en_t;                  // cycles since scanning (re)started
  logic [3:0] m_dig [N];
  logic       m_dp [N];
  logic       m_blank [N];
  logic [N-1:0] e_an;
  logic [6:0]   e_seg;
  logic         e_dp, e_hb;
  logic [M-1:0] e_sw, e_rise, e_fall;
  logic [M-1:0] samp1, samp2;        // pin as seen one and two edges ago
  int           run [M];             // length of current disagreement run
  int           hb_n;

  task automatic m_load();
    for (int i = 0; i < N; i++) begin
      m_dig[i]   = digits_i[4*i +: 4];
      m_dp[i]    = dp_i[i];
      m_blank[i] = blank_i[i];
    end
  endtask

  always @(posedge clk) begin
    logic [M-1:0] seen;
    int k;
    if (reset) begin
      m_valid = 1;
      en_t = 0;
      for (int i = 0; i < N; i++) begin m_dig[i] = 0; m_dp[i] = 0; m_blank[i] = 0; end
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
      samp1 = '0; samp2 = '0; e_sw = '0; e_rise = '0; e_fall = '0;
      for (int i = 0; i < M; i++) run[i] = 0;
      hb_n = 0; e_hb = 1'b0;
    end else begin
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
      if (!enable_i) begin
        m_load();
        en_t = 0;
      end else begin
        k = (en_t / SC) % N;
        if (!m_blank[k]) begin
          e_an  = ~(N'(1) << k);
          e_seg = hex_tab[m_dig[k]];
          e_dp  = ~m_dp[k];
        end
        if (en_t % (SC * N) == SC * N - 1) m_load();
        en_t++;
      end
      seen = samp2;
      samp2 = samp1;
      samp1 = sw_i;
      e_rise = '0; e_fall = '0;
      for (int i = 0; i < M; i++) begin
        if (seen[i] != e_sw[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            e_sw[i] = seen[i];
            e_rise[i] = seen[i];
            e_fall[i] = ~seen[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      hb_n++;
      e_hb = ((hb_n >> HB) & 1) != 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("an_o", an_o, e_an);
      chk("seg_o", seg_o, e_seg);
      chk("dp_o", dp_o, e_dp);
      chk("sw_o", sw_o, e_sw);
      chk("sw_rise_o", sw_rise_o, e_rise);
      chk("sw_fall_o", sw_fall_o, e_fall);
      chk("heartbeat_o", heartbeat_o, e_hb);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] lit_an [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] lit_seg [4] = '{7'b1000000, 7'b1111001, 7'b0000000, 7'b0001110};

  initial begin
    reset = 1; enable_i = 1; digits_i = 16'hF810; dp_i = '0; blank_i = '0; sw_i = '0;
    tick(2);
    chk("reset_an", an_o, 4'hF);
    chk("reset_seg", seg_o, 7'h7F);
    chk("reset_dp", dp_o, 1'b1);
    chk("reset_sw", sw_o, 3'b000);
    chk("reset_hb", heartbeat_o, 1'b0);
    reset = 0;

    // T1: first frame shows reset shadow, then F810 frame
    tick(16);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < SC; c++) begin
        tick(1);
        chk("t1_an", an_o, lit_an[d]);
        chk("t1_seg", seg_o, lit_seg[d]);
      end
    end
    tick(6);
    reset = 1;
    tick(1);
    chk("t1_midreset_an", an_o, 4'hF);
    reset = 0;

    // T2: change digits mid-frame
    tick(21);
    digits_i = 16'hAAAA;
    tick(4);
    chk("t2_old_d2", seg_o, 7'b0000000);
    tick(4);
    chk("t2_old_d3", seg_o, 7'b0001110);
    tick(4);
    chk("t2_new_an", an_o, 4'b1110);
    chk("t2_new_seg", seg_o, 7'b0001000);

    // T3: blank digit 2, dp on digit 0
    blank_i = 4'b0100; dp_i = 4'b0001;
    tick(16);
    chk("t3_d0_an", an_o, 4'b1110);
    chk("t3_d0_dp", dp_o, 1'b0);
    tick(4);
    chk("t3_d1_dp", dp_o, 1'b1);
    tick(4);
    chk("t3_d2_an", an_o, 4'b1111);
    tick(4);
    chk("t3_d3_an", an_o, 4'b0111);

    // T4: disable for 3 cycles then re-enable
    enable_i = 0;
    tick(1);
    chk("t4_dark_an", an_o, 4'hF);
    chk("t4_dark_seg", seg_o, 7'h7F);
    tick(2);
    enable_i = 1;
    tick(1);
    chk("t4_reen_an", an_o, 4'b1110);
    chk("t4_reen_seg", seg_o, 7'b0001000);
    blank_i = '0;

    // T5: debouncer
    sw_i = 3'b010;
    tick(6);
    chk("t5_before", sw_o, 3'b000);
    tick(1);
    chk("t5_sw", sw_o, 3'b010);
    chk("t5_rise", sw_rise_o, 3'b010);
    tick(1);
    chk("t5_rise_once", sw_rise_o, 3'b000);
    sw_i = 3'b011;
    tick(4);
    sw_i = 3'b010;
    tick(10);
    chk("t5_glitch", sw_o, 3'b010);
    sw_i = 3'b110;
    tick(7);
    chk("t5_sw2_on", sw_o, 3'b110);
    sw_i = 3'b010;
    tick(7);
    chk("t5_fall", sw_fall_o, 3'b100);
    chk("t5_sw2_off", sw_o, 3'b010);
    sw_i = 3'b101;
    tick(7);
    chk("t5_multi_sw", sw_o, 3'b101);
    chk("t5_multi_rise", sw_rise_o, 3'b101);
    chk("t5_multi_fall", sw_fall_o, 3'b010);

    // reset mid-debounce, then T6 heartbeat
    sw_i = 3'b010;
    tick(3);
    reset = 1;
    tick(1);
    chk("t6_reset_sw", sw_o, 3'b000);
    reset = 0;
    for (int i = 1; i <= 32; i++) begin
      tick(1);
      chk("t6_hb", heartbeat_o, (i / 8) % 2);
    end
    tick(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
